// File: rtl/l0_scaler_readout_ctrl.sv
// Per-channel pulse scalers gated over a fixed period, snapshotted at period end and streamed out over valid/ready.
// Optional macro SCALER_REF_GATE_EN: gate on rising edges of ref_pulse_i instead of the internal PERIOD counter.
module l0_scaler_readout_ctrl #(
  parameter int NCH    = 22,
  parameter int WIDTH  = 16,
  parameter int PERIOD = 33333,
  parameter int CHW    = 5
) (
  input  logic             mclk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   scal_i,
  input  logic             ref_pulse_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CHW-1:0]   chan_o,
  output logic             valid_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic             overrun_o,
  input  logic             ovr_clr_i
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t           state;
  logic             eop;
  logic             xfer;
  logic             last_xfer;
  logic             take_snap;
  logic [CHW-1:0]   next_chan;
  logic [WIDTH-1:0] cnt  [NCH];
  logic [WIDTH-1:0] snap [NCH];
  logic [WIDTH-1:0] inc  [NCH];

`ifdef SCALER_REF_GATE_EN
  localparam int period_unused = PERIOD;
  logic ref_q;

  always_ff @(posedge mclk_i) begin
    if (rst_i) ref_q <= 1'b0;
    else       ref_q <= ref_pulse_i;
  end

  assign eop = ref_pulse_i & ~ref_q;
`else
  logic [23:0] per_cnt;
  logic        ref_unused;

  assign ref_unused = ref_pulse_i;

  always_ff @(posedge mclk_i) begin
    if (rst_i)    per_cnt <= '0;
    else if (eop) per_cnt <= '0;
    else          per_cnt <= per_cnt + 24'd1;
  end

  assign eop = (per_cnt == 24'(PERIOD - 1));
`endif

  // Saturating next count; on eop this is also the value the snapshot captures.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      inc[i] = (&cnt[i]) ? cnt[i] : cnt[i] + WIDTH'(scal_i[i]);
    end
  end

  assign xfer      = valid_o & ready_i;
  assign last_xfer = xfer & last_o;
  assign take_snap = eop & ((state == IDLE) | last_xfer);
  assign next_chan = chan_o + CHW'(1);

  always_ff @(posedge mclk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= eop ? '0 : inc[i];
        if (take_snap) snap[i] <= inc[i];
      end
    end
  end

  // Channel 0 comes straight from inc[] because the snapshot is written in the same cycle.
  always_ff @(posedge mclk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      valid_o   <= 1'b0;
      chan_o    <= '0;
      dout_o    <= '0;
      last_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (eop && (state == STREAM) && !last_xfer) overrun_o <= 1'b1;
      else if (ovr_clr_i)                          overrun_o <= 1'b0;

      case (state)
        IDLE: begin
          if (eop) begin
            state   <= STREAM;
            valid_o <= 1'b1;
            chan_o  <= '0;
            dout_o  <= inc[0];
            last_o  <= (NCH == 1);
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_o) begin
              if (eop) begin
                valid_o <= 1'b1;
                chan_o  <= '0;
                dout_o  <= inc[0];
                last_o  <= (NCH == 1);
              end else begin
                state   <= IDLE;
                valid_o <= 1'b0;
                chan_o  <= '0;
                dout_o  <= '0;
                last_o  <= 1'b0;
              end
            end else begin
              chan_o <= next_chan;
              dout_o <= snap[next_chan];
              last_o <= (next_chan == CHW'(NCH - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l0_scaler_readout_ctrl.sv
// Scoreboard bench: a 16-bit and a 4-bit (saturating) instance run in lockstep with PERIOD=100.
module tb_l0_scaler_readout_ctrl;

  localparam int NCH    = 22;
  localparam int CHW    = 5;
  localparam int PERIOD = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           ready = 1'b0;
  logic           ovr_clr = 1'b0;
  logic           ref_pulse = 1'b0;
  logic [NCH-1:0] scal = '0;

  logic [15:0]    dout_w;
  logic [3:0]     dout_n;
  logic [CHW-1:0] chan_w, chan_n;
  logic           valid_w, valid_n, last_w, last_n, ovr_w, ovr_n;

  l0_scaler_readout_ctrl #(.NCH(NCH), .WIDTH(16), .PERIOD(PERIOD), .CHW(CHW)) dut_w (
    .mclk_i(clk), .rst_i(rst), .scal_i(scal), .ref_pulse_i(ref_pulse),
    .dout_o(dout_w), .chan_o(chan_w), .valid_o(valid_w), .last_o(last_w),
    .ready_i(ready), .overrun_o(ovr_w), .ovr_clr_i(ovr_clr)
  );

  l0_scaler_readout_ctrl #(.NCH(NCH), .WIDTH(4), .PERIOD(PERIOD), .CHW(CHW)) dut_n (
    .mclk_i(clk), .rst_i(rst), .scal_i(scal), .ref_pulse_i(ref_pulse),
    .dout_o(dout_n), .chan_o(chan_n), .valid_o(valid_n), .last_o(last_n),
    .ready_i(ready), .overrun_o(ovr_n), .ovr_clr_i(ovr_clr)
  );

  typedef struct {
    int chan;
    int data;
    bit last;
  } word_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    acc[NCH];
  int    pc = 0;
  bit    drop_eop = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pushFrame();
    word_t w;
    for (int ch = 0; ch < NCH; ch++) begin
      w.chan = ch;
      w.data = (acc[ch] > 65535) ? 65535 : acc[ch];
      w.last = (ch == NCH - 1);
      exp_q.push_back(w);
    end
  endtask

  // One clock: drive inputs, take the edge, account pulses in the bench's own period model.
  task automatic applyStimulus(input logic [NCH-1:0] s, input logic r);
    scal      = s;
    ready     = r;
    ref_pulse = ~ref_pulse;
    @(posedge clk);
    if (!rst) begin
      for (int ch = 0; ch < NCH; ch++) acc[ch] += int'(s[ch]);
      if (pc == PERIOD - 1) begin
        if (drop_eop) drop_eop = 1'b0;
        else          pushFrame();
        for (int ch = 0; ch < NCH; ch++) acc[ch] = 0;
        pc = 0;
      end else begin
        pc++;
      end
    end
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    exp_q.delete();
    pc = 0;
    drop_eop = 1'b0;
    for (int ch = 0; ch < NCH; ch++) acc[ch] = 0;
    applyStimulus('0, 1'b1);
    checkOutput("rst_valid_w", 32'(valid_w), 0);
    checkOutput("rst_valid_n", 32'(valid_n), 0);
    repeat (n - 1) applyStimulus('0, 1'b1);
    checkOutput("rst_dout", 32'(dout_w), 0);
    checkOutput("rst_chan", 32'(chan_w), 0);
    checkOutput("rst_last", 32'(last_w), 0);
    checkOutput("rst_overrun", 32'(ovr_w), 0);
    rst = 1'b0;
  endtask

  // Monitor: pops one expected word per accepted transfer, and checks that stalled words hold still.
  word_t          mw;
  logic           pv = 1'b0, pr = 1'b0, plast = 1'b0;
  logic [CHW-1:0] pchan = '0;
  logic [15:0]    pdout = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        checkOutput("hold_valid", 32'(valid_w), 1);
        checkOutput("hold_chan", 32'(chan_w), 32'(pchan));
        checkOutput("hold_dout", 32'(dout_w), 32'(pdout));
        checkOutput("hold_last", 32'(last_w), 32'(plast));
      end
      if (valid_w || valid_n) begin
        checkOutput("valid_w", 32'(valid_w), 1);
        checkOutput("valid_n", 32'(valid_n), 1);
        if (ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_word: got chan %0d data %0d expected no word", chan_w, dout_w);
          end else begin
            mw = exp_q.pop_front();
            checkOutput("chan_w", 32'(chan_w), mw.chan);
            checkOutput("dout_w", 32'(dout_w), mw.data);
            checkOutput("last_w", 32'(last_w), 32'(mw.last));
            checkOutput("chan_n", 32'(chan_n), mw.chan);
            checkOutput("dout_n", 32'(dout_n), (mw.data > 15) ? 15 : mw.data);
            checkOutput("last_n", 32'(last_n), 32'(mw.last));
          end
        end
      end
      pv    = valid_w;
      pr    = ready;
      pchan = chan_w;
      pdout = dout_w;
      plast = last_w;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: got no finish expected finish before 50000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NCH-1:0] s;
    doReset(4);

    // Basic count: ch3 for 10 cycles, ch21 every cycle; frame 1 at eop edge 99.
    for (int k = 0; k < 100; k++) begin
      s = '0;
      s[21] = 1'b1;
      s[3]  = (k < 10);
      applyStimulus(s, 1'b1);
    end

    // Frame 1 streams freely; ch i pulses (i % 8) times, re-counting after saturation.
    for (int k = 0; k < 100; k++) begin
      s = '0;
      for (int ch = 0; ch < NCH; ch++) s[ch] = (k < (ch % 8));
      applyStimulus(s, 1'b1);
    end

    // Backpressure on frame 2: stall 5 cycles at chan 7, then ready every other cycle.
    for (int k = 0; k < 100; k++) begin
      s = '0;
      s[10] = (k >= 50 && k < 57);
      applyStimulus(s, (k < 7) ? 1'b1 : (k < 12) ? 1'b0 : ((k - 12) % 2 == 0));
    end

    // Frame 3 stalled across the next eop: overrun, that period's counts are dropped.
    drop_eop = 1'b1;
    for (int k = 0; k < 100; k++) begin
      s = '0;
      s[5] = 1'b1;
      applyStimulus(s, 1'b0);
      if (k == 98) checkOutput("overrun_before_eop", 32'(ovr_w), 0);
    end
    checkOutput("overrun_set_w", 32'(ovr_w), 1);
    checkOutput("overrun_set_n", 32'(ovr_n), 1);

    // Release frame 3 with original values, then clear overrun.
    for (int k = 0; k < 100; k++) begin
      s = '0;
      s[2] = (k >= 85 && k < 89);
      ovr_clr = (k == 80);
      applyStimulus(s, (k >= 50));
      if (k == 79) checkOutput("overrun_sticky", 32'(ovr_w), 1);
      if (k == 80) checkOutput("overrun_cleared", 32'(ovr_w), 0);
    end
    ovr_clr = 1'b0;

    // Frame 5's last transfer coincides with eop; the eop-cycle pulse on ch1 belongs to this period.
    for (int k = 0; k < 100; k++) begin
      s = '0;
      s[0] = (k >= 10 && k < 13);
      s[1] = (k == 99);
      applyStimulus(s, (k >= 78));
    end
    checkOutput("b2b_valid", 32'(valid_w), 1);
    checkOutput("b2b_chan", 32'(chan_w), 0);
    checkOutput("b2b_dout", 32'(dout_w), 3);
    checkOutput("b2b_no_overrun", 32'(ovr_w), 0);

    // Frame 7 streams until chan 9, then a mid-frame reset abandons it.
    for (int k = 0; k < 109; k++) begin
      s = '0;
      s[1] = (k == 0);
      s[4] = (k < 100);
      applyStimulus(s, 1'b1);
    end
    doReset(2);

    // First period after reset release: only its own pulses appear.
    for (int k = 0; k < 130; k++) begin
      s = '0;
      s[8] = (k >= 20 && k < 29);
      applyStimulus(s, 1'b1);
    end

    checkOutput("all_words_delivered", exp_q.size(), 0);
    checkOutput("final_idle", 32'(valid_w), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l0_scaler_readout_ctrl.md
Name: l0_scaler_readout_ctrl

Overview:
- Sequences readout of the per-channel scaler pulse stream leaving the TURF trigger processor: L0 scalers, L1 scalers, L2 scalers and the registered reference pulse.
- Counts single-cycle pulses per channel over a fixed gate period on the 33 MHz master clock.
- Snapshots all counts at period end, then streams them out one channel per transfer over a valid/ready handshake to the scaler readout bus.

Parameters:
- NCH, 22, number of pulse input channels.
- WIDTH, 16, counter/data width in bits; counters saturate.
- PERIOD, 33333, gate length in mclk_i cycles (1 ms at 33.33 MHz); legal range 2..2^24-1.
- CHW, 5, channel index width; must satisfy 2^CHW >= NCH.

Ports:
- mclk_i  input  1  master clock; all logic on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- scal_i  input  NCH  per-channel pulses, synchronous to mclk_i; each high cycle counts as one event.
- ref_pulse_i  input  1  TURF reference pulse, synchronous to mclk_i; used only with SCALER_REF_GATE_EN.
- dout_o  output  WIDTH  snapshot count for channel chan_o.
- chan_o  output  CHW  channel index of dout_o.
- valid_o  output  1  dout_o/chan_o/last_o valid.
- last_o  output  1  high with the final channel (NCH-1) of a frame.
- ready_i  input  1  consumer accepts the word when valid_o & ready_i.
- overrun_o  output  1  sticky: a period ended while a frame was still streaming.
- ovr_clr_i  input  1  synchronous clear of overrun_o.

Behaviour:
- Reset (rst_i high at a clock edge):
  - all counters, snapshot bank and period counter go to 0; state goes to IDLE.
  - outputs: dout_o=0, chan_o=0, valid_o=0, last_o=0, overrun_o=0.
  - Reset mid-frame abandons the frame immediately; valid_o is low on the next cycle.
- Period counter:
  - counts 0..PERIOD-1 and wraps.
  - end-of-period strobe eop is high for one cycle when count==PERIOD-1.
- Channel counters (WIDTH bits each):
  - On a non-eop cycle: cnt[i] <= cnt[i] + scal_i[i], saturating at 2^WIDTH-1 (no wrap).
  - On an eop cycle: snapshot[i] captures cnt[i] + scal_i[i] (saturated), and cnt[i] reloads to 0. The eop-cycle pulse therefore belongs to the ending period and no pulse is lost or double-counted.
- State machine:
  - IDLE to STREAM on eop. The snapshot is taken in the eop cycle E. valid_o=1, chan_o=0, dout_o=snapshot[0] from cycle E+1.
  - STREAM: dout_o/chan_o/last_o are held stable while valid_o & !ready_i.
    - On each transfer (valid_o & ready_i), chan_o increments and dout_o=snapshot[chan_o+1] on the next cycle.
    - last_o=1 exactly when chan_o==NCH-1.
    - The transfer with last_o=1 returns to IDLE; valid_o=0 the following cycle.
  - Throughput: one word per cycle with ready_i held high, so a frame takes NCH cycles.
- Overrun (eop while in STREAM):
  - The snapshot bank is NOT overwritten and the current frame continues intact. The counts of the ending period are discarded; counters still reload to 0.
  - overrun_o is set. If ovr_clr_i and a new overrun occur in the same cycle, set wins.
  - eop coinciding with the final (last_o) transfer is not an overrun: the new snapshot is taken and STREAM restarts at chan 0 on the next cycle without an idle cycle.
- ovr_clr_i has no effect on counting or streaming.

Optional Feature:
- Macro SCALER_REF_GATE_EN.
- When defined:
  - the period counter and PERIOD are unused.
  - eop is the rising edge of ref_pulse_i: registered ref_pulse_i low, current ref_pulse_i high, detected in the same cycle.
  - The gate is the interval between consecutive reference pulses. The first edge after reset produces a frame covering reset-to-edge.
- When undefined: ref_pulse_i is ignored and eop comes from the internal PERIOD counter.

Test Plan:
- Use PERIOD=100 unless stated otherwise.
- Basic count: after reset, pulse channel 3 on 10 cycles and channel 21 on every cycle, ready_i=1 -> first frame at cycle 101: chan 3 = 10, chan 21 = 100, all others 0; last_o only on chan 21; valid_o low after 22 words.
- Backpressure: hold ready_i=0 for 5 cycles at chan 7, then toggle ready_i every other cycle -> chan_o/dout_o stable while stalled; all 22 words delivered exactly once, in order.
- Saturation: WIDTH=4, channel 0 high for all 100 cycles -> chan 0 reads 15; next period with 3 pulses reads 3.
- Overrun: ready_i=0 for 150 cycles after the first frame starts -> overrun_o=1; the first frame still delivers the original values; ovr_clr_i pulse -> overrun_o=0.
- Reset mid-frame: assert rst_i at chan 9 -> valid_o=0 the next cycle; the next frame appears 100 cycles after reset release with counts from that period only.
- SCALER_REF_GATE_EN: ref_pulse_i rising edges 40 cycles apart, channel 1 high continuously -> every frame after the first reports chan 1 = 40.
